// File: rtl/mac_rx_pkg.sv
// ---------------------------------------------------------------------------
// mac_rx_pkg
// Shared definitions for the MAC RX frame buffer:
//   - layout of the 37-bit buffered word {tlast, tkeep[3:0], tdata[31:0]}
//   - write-side FSM state encoding
//   - saturating 16-bit increment used by the frame statistics
// ---------------------------------------------------------------------------
package mac_rx_pkg;

  localparam int DATA_W   = 32;
  localparam int KEEP_W   = 4;
  localparam int PIPE_W   = 37;
  localparam int LAST_BIT = 36;
  localparam int KEEP_MSB = 35;
  localparam int KEEP_LSB = 32;
  localparam int STAT_W   = 16;

  // SYNC: waiting for a frame boundary after reset
  // IDLE: between frames (wr_ptr == commit_ptr)
  // RECV: inside a frame that is being stored
  // DROP: inside a frame that no longer fits; beats discarded until tlast
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_RECV = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] value,
                                                  input logic              en);
    if (en && (value != {STAT_W{1'b1}})) begin
      return value + STAT_W'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/mac_rx_sdp_ram.sv
// ---------------------------------------------------------------------------
// mac_rx_sdp_ram
// Simple dual-port RAM: one write port, one synchronous read port, same clock.
// The storage array has no reset so it maps onto block RAM.
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates one cycle later and holds
//                 its value while re_i is low
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module mac_rx_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 37
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mac_rx_frame_to_pipe.sv
// ---------------------------------------------------------------------------
// mac_rx_frame_to_pipe
// Frame buffer between the 10G MAC RX AXI-Stream master (no tready) and the
// AHIR write pipe. Every incoming frame is stored and only becomes readable
// after its tlast beat arrives with tuser=1. Bad frames (tuser=0 on tlast)
// and frames that do not fit are removed completely, so the pipe consumer
// only ever sees whole good frames.
//
// Optional feature macro: MAC_RX_STATS_EN
//   defined   -> stat_ok / stat_bad / stat_ovf saturating frame counters
//   undefined -> counters absent, stat_* outputs tied to zero
//
// Ports:
//   clk              in   core clock, rising edge
//   aresetn          in   asynchronous active-low reset
//   rx_axis_tdata    in   MAC RX data
//   rx_axis_tkeep    in   byte valid, contiguous from bit 0
//   rx_axis_tvalid   in   beat valid (no backpressure)
//   rx_axis_tlast    in   last beat of frame
//   rx_axis_tuser    in   frame good, looked at on the tlast beat only
//   pipe_write_req   out  output word valid
//   pipe_write_ack   in   consumer accept; transfer = req & ack
//   pipe_write_data  out  {tlast, tkeep, tdata}
//   fifo_words       out  words written and not yet read from the buffer
//   stat_ok          out  good frame count
//   stat_bad         out  bad-FCS frame count
//   stat_ovf         out  overflow-dropped frame count
// ---------------------------------------------------------------------------
module mac_rx_frame_to_pipe
  import mac_rx_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] rx_axis_tdata,
  input  logic [KEEP_W-1:0] rx_axis_tkeep,
  input  logic              rx_axis_tvalid,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  output logic              pipe_write_req,
  input  logic              pipe_write_ack,
  output logic [PIPE_W-1:0] pipe_write_data,
  output logic [AW:0]       fifo_words,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_bad,
  output logic [STAT_W-1:0] stat_ovf
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  //   wr_ptr_q     : next free slot (includes the frame in progress)
  //   commit_ptr_q : end of the last good frame; reads never pass it
  //   rd_ptr_q     : next slot to fetch from RAM
  // -------------------------------------------------------------------------
  rx_state_e   state_q;
  logic [AW:0] wr_ptr_q;
  logic [AW:0] commit_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;

  logic              beat;
  logic              in_frame;
  logic              buf_full;
  logic              frame_full;
  logic              no_room;
  logic              wr_en;
  logic [PIPE_W-1:0] wr_word;

  assign beat     = rx_axis_tvalid;
  assign in_frame = (state_q == ST_IDLE) || (state_q == ST_RECV);

  // Full is judged on the pre-update rd_ptr: a slot freed by a read this
  // cycle only becomes writable next cycle.
  assign buf_full   = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
  // A frame that already holds DEPTH words can never be committed, even if
  // the reader keeps up, so treat it as overflow too.
  assign frame_full = ((wr_ptr_q - commit_ptr_q) == DEPTH_P);
  assign no_room    = buf_full || frame_full;

  assign wr_en   = beat && in_frame && !no_room;
  assign wr_word = {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};

  // -------------------------------------------------------------------------
  // Write-side FSM. State only moves on a valid beat.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_SYNC;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
    end else if (beat) begin
      unique case (state_q)
        ST_SYNC: begin
          // Drop whatever tail of a frame was in flight at reset release.
          if (rx_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE, ST_RECV: begin
          if (no_room) begin
            // Throw away the partial frame; wait for its end in DROP unless
            // this overflowing beat already is the end.
            wr_ptr_q <= commit_ptr_q;
            state_q  <= rx_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (rx_axis_tlast) begin
            state_q <= ST_IDLE;
            if (rx_axis_tuser) begin
              wr_ptr_q     <= wr_ptr_q + PTR_ONE;
              commit_ptr_q <= wr_ptr_q + PTR_ONE;
            end else begin
              wr_ptr_q <= commit_ptr_q;
            end
          end else begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            state_q  <= ST_RECV;
          end
        end
        ST_DROP: begin
          if (rx_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign fifo_words = wr_ptr_q - rd_ptr_q;

  // -------------------------------------------------------------------------
  // Buffer RAM
  // -------------------------------------------------------------------------
  logic              rd_issue;
  logic [PIPE_W-1:0] ram_rdata;

  mac_rx_sdp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (PIPE_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_word),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // -------------------------------------------------------------------------
  // Read side: two-stage prefetch.
  //   ram_valid_q : the RAM read register holds a fetched word
  //   out_valid_q : the output register holds a word (drives req)
  // A new fetch is issued whenever the RAM stage will be empty after this
  // edge, which keeps one word per cycle flowing while ack stays high.
  // The RAM read register holds its value when no read is issued, so a
  // fetched word simply waits there while the output is stalled.
  // -------------------------------------------------------------------------
  logic              ram_valid_q;
  logic              ram_valid_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [PIPE_W-1:0] out_data_q;
  logic [PIPE_W-1:0] out_data_d;
  logic              out_free;
  logic              stage_free;
  logic              load_out;

  always_comb begin
    out_free    = !out_valid_q || pipe_write_ack;
    stage_free  = !ram_valid_q || out_free;
    rd_issue    = (rd_ptr_q != commit_ptr_q) && stage_free;
    load_out    = ram_valid_q && out_free;
    rd_ptr_d    = rd_issue ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    ram_valid_d = rd_issue || (ram_valid_q && !out_free);
    out_valid_d = load_out || (out_valid_q && !pipe_write_ack);
    out_data_d  = load_out ? ram_rdata : out_data_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q    <= '0;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign pipe_write_req  = out_valid_q;
  assign pipe_write_data = out_data_q;

  // -------------------------------------------------------------------------
  // Frame statistics
  // -------------------------------------------------------------------------
`ifdef MAC_RX_STATS_EN
  logic              ok_evt;
  logic              bad_evt;
  logic              ovf_evt;
  logic [STAT_W-1:0] stat_ok_q;
  logic [STAT_W-1:0] stat_bad_q;
  logic [STAT_W-1:0] stat_ovf_q;

  assign ok_evt  = wr_en && rx_axis_tlast && rx_axis_tuser;
  assign bad_evt = wr_en && rx_axis_tlast && !rx_axis_tuser;
  // A frame counts as overflowed once, at its tlast: either the tlast beat
  // itself found no room, or the frame was already being dropped.
  assign ovf_evt = beat && rx_axis_tlast &&
                   ((in_frame && no_room) || (state_q == ST_DROP));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_ok_q  <= '0;
      stat_bad_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ok_q  <= sat_inc16(stat_ok_q, ok_evt);
      stat_bad_q <= sat_inc16(stat_bad_q, bad_evt);
      stat_ovf_q <= sat_inc16(stat_ovf_q, ovf_evt);
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_bad = stat_bad_q;
  assign stat_ovf = stat_ovf_q;
`else
  assign stat_ok  = '0;
  assign stat_bad = '0;
  assign stat_ovf = '0;
`endif

endmodule
